neuron_frame_loader: RTL
========================

# neuron_frame_loader

Sequential front end for the combinational 8-input neuron datapath. It accepts a byte stream over a valid/ready handshake, assembles one operand frame of weights, inputs and bias into registers, drives them in parallel to the neuron, then captures the neuron's 12-bit sum. The sum is returned as a single result word over a second valid/ready handshake. It sits between the serial operand source (DMA or host shim) and the neuron.

## Interface
- N_TAPS, 8, operand pairs per frame; the only supported value.
- DATA_W, 8, operand byte width.
- RES_W, 12, neuron result width.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader can accept a byte.
- s_data  in  DATA_W  stream byte.
- s_last  in  1  final byte of frame; must be high exactly on the bias byte.
- reuse_w  in  1  sampled on a frame's first accepted byte; 1 = short frame reusing stored weights.
- w_flat  out  N_TAPS*DATA_W  weights to neuron; w1 at [7:0], w8 at [63:56].
- x_flat  out  N_TAPS*DATA_W  inputs to neuron; same packing.
- bias  out  DATA_W  bias to neuron.
- nrn_out  in  RES_W  combinational neuron sum.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  RES_W  captured result.
- w_loaded  out  1  stored weights are complete and usable.
- frame_err  out  1  one-cycle pulse on framing error.

## Operation
- Full frame, 17 bytes: w1..w8, x1..x8, bias. Short frame, 9 bytes: x1..x8, bias.
- A byte is accepted when s_valid & s_ready.
- States: IDLE, LOAD_W, LOAD_X, LOAD_B, SETTLE, OUT. A 3-bit idx counts bytes within LOAD_W and LOAD_X.
- IDLE, byte accepted:
  - If reuse_w & w_loaded: byte goes to x1, idx=1, next state LOAD_X.
  - Otherwise (full frame): byte goes to w1, idx=1, next state LOAD_W.
  - reuse_w with w_loaded=0 is treated as a full frame.
- LOAD_W: each byte goes to w[idx]. After the idx=7 byte: w_loaded<=1, idx=0, next state LOAD_X.
- LOAD_X: each byte goes to x[idx]. After the idx=7 byte, next state LOAD_B.
- LOAD_B: the byte goes to bias, next state SETTLE.
- SETTLE: m_data<=nrn_out, next state OUT.
- OUT: m_valid=1. On m_ready, next state IDLE. m_data and m_valid stay stable until accepted.
- s_ready is 1 in IDLE, LOAD_W, LOAD_X and LOAD_B; 0 in SETTLE and OUT.
- Framing error: s_last=1 on any non-bias byte, or s_last=0 on the bias byte.
  - frame_err pulses the following cycle and the state returns to IDLE; no result is produced.
  - If the error occurs while loading weights (IDLE full-frame start or LOAD_W), w_loaded<=0.
  - Bytes already written stay in the operand registers; this is harmless because no result is produced.
- Operand registers change only on accepted bytes, so the neuron inputs are stable during SETTLE and OUT.

## Timing
- Reset values: state IDLE, idx 0, w_flat/x_flat/bias/m_data 0, m_valid 0, w_loaded 0, frame_err 0. s_ready is 1 because it decodes IDLE.
- Latency: bias byte accepted in cycle T; SETTLE in T+1; m_valid high from T+2.
- Throughput:
  - Full frame: 17 accept cycles + SETTLE + at least 1 OUT cycle = 19 cycles minimum.
  - Short frame: 11 cycles minimum.
- With m_ready held high, m_valid is a one-cycle pulse and the next frame's first byte can be accepted in T+3.
- Back-pressure: s_valid low inserts bubbles with no state change. m_ready low holds OUT indefinitely.
- Reset asserted mid-frame or in OUT: immediate abort to reset values, w_loaded cleared, the pending result is lost.
- frame_err and m_valid are never high in the same cycle.

## Structure
- Shared package nn_stream_pkg: state enum; constants FULL_FRAME_LEN=17, SHORT_FRAME_LEN=9, N_TAPS, DATA_W, RES_W.
- The package is shared with the stream source and testbench.
- One natural sub-module, neuron_operand_bank, contains:
  - The w/x/bias register file, with write-enable, select (W/X/B) and index inputs.
  - The flat packing of w_flat and x_flat.
- The FSM, counter, result register and handshakes stay in the top module.
- The neuron is instantiated outside this block; the testbench uses a behavioural model of it.

## Test plan
- Full frame, w=1..8, x=2 for all, bias=3, s_last on byte 17 -> w_loaded=1; m_valid two cycles after the bias byte with m_data = model(operands); no pulse on frame_err.
- Short frame with reuse_w=1 after the above, x=1..8, bias=0 -> weights unchanged; m_data = model result; 9 bytes consumed.
- Short frame with reuse_w=1 straight after reset -> treated as full frame; w_loaded rises only after byte 8.
- s_last high on byte 5 of a full frame -> frame_err pulse, w_loaded=0, no m_valid; the next valid frame succeeds.
- m_ready held low 10 cycles in OUT, with s_valid high throughout -> s_ready stays 0; m_data stays stable; exactly one result transfer occurs.
- rst_n pulsed low during LOAD_X -> all outputs return to reset values; the next 17-byte frame completes correctly.

Source files
------------

// File: rtl/nn_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : nn_stream_pkg
//  Description : Shared definitions for the neuron operand stream: frame
//                geometry, datapath widths, loader state encoding and
//                operand-bank select codes. Used by the stream source, the
//                loader and the testbench.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_stream_pkg;

  localparam int N_TAPS          = 8;
  localparam int DATA_W          = 8;
  localparam int RES_W           = 12;
  localparam int FULL_FRAME_LEN  = 2 * N_TAPS + 1;  // w1..w8, x1..x8, bias
  localparam int SHORT_FRAME_LEN = N_TAPS + 1;      // x1..x8, bias
  localparam int IDX_W           = $clog2(N_TAPS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_SETTLE = 3'd4,
    ST_OUT    = 3'd5
  } nfl_state_t;

  // Operand-bank write select
  localparam logic [1:0] SEL_W = 2'd0;
  localparam logic [1:0] SEL_X = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;

endpackage
`default_nettype wire

// File: rtl/neuron_operand_bank.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_operand_bank
//  Description : Register file holding one neuron operand frame (N_TAPS
//                weights, N_TAPS inputs, one bias) and presenting the weights
//                and inputs as flat buses, tap 1 in the least significant
//                byte.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                i_we              - write enable for one byte
//                i_sel             - target array (SEL_W / SEL_X / SEL_B)
//                i_idx             - tap index within the W or X array
//                i_data            - byte to write
//                o_w_flat/o_x_flat - packed weights / inputs
//                o_bias            - bias byte
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_operand_bank #(
  parameter int N_TAPS = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_we,
  input  logic [1:0]                 i_sel,
  input  logic [$clog2(N_TAPS)-1:0]  i_idx,
  input  logic [DATA_W-1:0]          i_data,
  output logic [N_TAPS*DATA_W-1:0]   o_w_flat,
  output logic [N_TAPS*DATA_W-1:0]   o_x_flat,
  output logic [DATA_W-1:0]          o_bias
);
  import nn_stream_pkg::*;

  logic [DATA_W-1:0] r_w [N_TAPS];
  logic [DATA_W-1:0] r_x [N_TAPS];
  logic [DATA_W-1:0] r_bias;

  // Registers only move on an accepted byte, so the neuron sees stable
  // operands while the loader waits for its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_w[i] <= '0;
        r_x[i] <= '0;
      end
      r_bias <= '0;
    end else if (i_we) begin
      case (i_sel)
        SEL_W:   r_w[i_idx] <= i_data;
        SEL_X:   r_x[i_idx] <= i_data;
        SEL_B:   r_bias     <= i_data;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_pack
    assign o_w_flat[g*DATA_W +: DATA_W] = r_w[g];
    assign o_x_flat[g*DATA_W +: DATA_W] = r_x[g];
  end

  assign o_bias = r_bias;

endmodule
`default_nettype wire

// File: rtl/neuron_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_frame_loader
//  Description : Sequential front end for the combinational 8-input neuron.
//                Assembles a byte-stream frame (full: w,x,bias / short:
//                x,bias reusing stored weights) into operand registers,
//                waits one settle cycle, captures the neuron sum and returns
//                it over a valid/ready result handshake.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                s_valid/s_ready/s_data   - operand byte stream
//                s_last                   - marks the bias byte
//                reuse_w                  - short-frame request (first byte)
//                w_flat/x_flat/bias       - operands to the neuron
//                nrn_out                  - neuron sum
//                m_valid/m_ready/m_data   - result handshake
//                w_loaded                 - stored weights are complete
//                frame_err                - one-cycle framing-error pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_frame_loader #(
  parameter int N_TAPS = 8,
  parameter int DATA_W = 8,
  parameter int RES_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_last,
  input  logic                      reuse_w,
  output logic [N_TAPS*DATA_W-1:0]  w_flat,
  output logic [N_TAPS*DATA_W-1:0]  x_flat,
  output logic [DATA_W-1:0]         bias,
  input  logic [RES_W-1:0]          nrn_out,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [RES_W-1:0]          m_data,
  output logic                      w_loaded,
  output logic                      frame_err
);
  import nn_stream_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TAPS - 1);

  nfl_state_t       r_state;
  nfl_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_bank_idx;
  logic [RES_W-1:0] r_m_data;
  logic             r_w_loaded;
  logic             r_frame_err;

  logic             w_s_ready;
  logic             w_m_valid;
  logic             w_accept;
  logic             w_err;
  logic             w_bank_we;
  logic [1:0]       w_bank_sel;
  logic             w_wl_set;
  logic             w_wl_clr;
  logic             w_capture;

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_m_data    <= '0;
      r_w_loaded  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame_err <= w_err;
      if (w_capture) begin
        r_m_data <= nrn_out;
      end
      if (w_wl_clr) begin
        r_w_loaded <= 1'b0;
      end else if (w_wl_set) begin
        r_w_loaded <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    w_bank_we   = 1'b0;
    w_bank_sel  = SEL_W;
    w_bank_idx  = r_idx;
    w_wl_set    = 1'b0;
    w_wl_clr    = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_s_ready  = 1'b1;
        w_accept   = s_valid;
        w_bank_idx = '0;
        if (w_accept) begin
          w_bank_we = 1'b1;
          w_idx_nxt = IDX_W'(1);
          // reuse_w only counts when a complete weight set is stored
          if (reuse_w && r_w_loaded) begin
            w_bank_sel  = SEL_X;
            w_state_nxt = ST_LOAD_X;
          end else begin
            w_bank_sel  = SEL_W;
            w_state_nxt = ST_LOAD_W;
            w_wl_clr    = s_last;
          end
          w_err = s_last;
        end
      end

      ST_LOAD_W: begin
        w_s_ready = 1'b1;
        w_accept  = s_valid;
        if (w_accept) begin
          w_bank_we  = 1'b1;
          w_bank_sel = SEL_W;
          w_idx_nxt  = r_idx + IDX_W'(1);  // wraps to 0 after the last tap
          if (s_last) begin
            w_err    = 1'b1;
            w_wl_clr = 1'b1;
          end else if (r_idx == LAST_IDX) begin
            w_wl_set    = 1'b1;
            w_state_nxt = ST_LOAD_X;
          end
        end
      end

      ST_LOAD_X: begin
        w_s_ready = 1'b1;
        w_accept  = s_valid;
        if (w_accept) begin
          w_bank_we  = 1'b1;
          w_bank_sel = SEL_X;
          w_idx_nxt  = r_idx + IDX_W'(1);
          if (s_last) begin
            w_err = 1'b1;
          end else if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_LOAD_B;
          end
        end
      end

      ST_LOAD_B: begin
        w_s_ready = 1'b1;
        w_accept  = s_valid;
        if (w_accept) begin
          w_bank_we  = 1'b1;
          w_bank_sel = SEL_B;
          if (!s_last) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
      end

      // Operands have been stable for a full cycle; sample the neuron.
      ST_SETTLE: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_OUT;
      end

      ST_OUT: begin
        w_m_valid = 1'b1;
        if (m_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // A framing error abandons the frame from any loading state.
    if (w_err) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Operand storage
  // --------------------------------------------------------------------------
  neuron_operand_bank #(
    .N_TAPS (N_TAPS),
    .DATA_W (DATA_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_bank_we),
    .i_sel    (w_bank_sel),
    .i_idx    (w_bank_idx),
    .i_data   (s_data),
    .o_w_flat (w_flat),
    .o_x_flat (x_flat),
    .o_bias   (bias)
  );

  assign s_ready   = w_s_ready;
  assign m_valid   = w_m_valid;
  assign m_data    = r_m_data;
  assign w_loaded  = r_w_loaded;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire
